// File: rtl/row_serializer.sv
// Row serializer: fetches one LENGTH-word row from the shift-RAM line buffer
// and streams it out LSB word first on a valid/ready interface.
module row_serializer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LENGTH     = 25,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [ADDR_WIDTH-1:0]        row_addr,
  output logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic [DATA_WIDTH*LENGTH-1:0] row_in,
  output logic [DATA_WIDTH-1:0]        dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic [CNT_WIDTH-1:0]         word_idx,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned ROW_WIDTH = DATA_WIDTH * LENGTH;
  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(LENGTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    SEND  = 2'd3
  } state_t;

  state_t               state;
  logic [ROW_WIDTH-1:0] shreg;

  // dout is a slice of the shift register, so it never sees row_in combinationally
  assign dout = shreg[DATA_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rd_addr    <= '0;
      shreg      <= '0;
      dout_valid <= 1'b0;
      word_idx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rd_addr <= row_addr;
            busy    <= 1'b1;
            state   <= FETCH;
          end
        end
        // line buffer samples rd_addr at the end of this cycle
        FETCH: state <= LOAD;
        LOAD: begin
          shreg      <= row_in;
          word_idx   <= '0;
          dout_valid <= 1'b1;
          state      <= SEND;
        end
        SEND: begin
          if (dout_valid && dout_ready) begin
            if (word_idx == LAST_IDX) begin
              dout_valid <= 1'b0;
              done       <= 1'b1;
              word_idx   <= '0;
              shreg      <= '0;
              busy       <= 1'b0;
              state      <= IDLE;
            end else begin
              shreg    <= {{DATA_WIDTH{1'b0}}, shreg[ROW_WIDTH-1:DATA_WIDTH]};
              word_idx <= word_idx + CNT_WIDTH'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_row_serializer.sv
// Directed bench for row_serializer: a LENGTH=4 instance fed by a registered
// line-buffer model, plus a default-parameter instance.
module tb_row_serializer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // LENGTH=4 instance
  logic        start4, dout_valid4, dout_ready4, busy4, done4;
  logic [7:0]  row_addr4, rd_addr4;
  logic [63:0] row_in4;
  logic [15:0] dout4;
  logic [1:0]  word_idx4;
  logic [63:0] mem4 [256];

  // default instance
  logic         start25, dout_valid25, dout_ready25, busy25, done25;
  logic [7:0]   row_addr25, rd_addr25;
  logic [399:0] row_in25;
  logic [15:0]  dout25;
  logic [4:0]   word_idx25;

  int checks = 0;
  int failures = 0;

  row_serializer #(.DATA_WIDTH(16), .LENGTH(4), .ADDR_WIDTH(8), .CNT_WIDTH(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .row_addr(row_addr4), .rd_addr(rd_addr4),
    .row_in(row_in4), .dout(dout4), .dout_valid(dout_valid4), .dout_ready(dout_ready4),
    .word_idx(word_idx4), .busy(busy4), .done(done4)
  );

  row_serializer dut25 (
    .clk(clk), .rst_n(rst_n), .start(start25), .row_addr(row_addr25), .rd_addr(rd_addr25),
    .row_in(row_in25), .dout(dout25), .dout_valid(dout_valid25), .dout_ready(dout_ready25),
    .word_idx(word_idx25), .busy(busy25), .done(done25)
  );

  // line buffer: output registered one clock after it samples rd_addr
  always @(posedge clk) row_in4 <= mem4[rd_addr4];

  typedef struct {
    logic [7:0]       addr;
    int               stall_word;
    int               stall_len;
    int               poke_word;
    logic [3:0][15:0] words;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_row(input vec_t v);
    int edges;
    @(negedge clk);
    start4 = 1'b1; row_addr4 = v.addr; dout_ready4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("rd_addr_after_start", 64'(rd_addr4), 64'(v.addr));
    check("busy_after_start", 64'(busy4), 64'd1);
    edges = 1;
    while (!dout_valid4 && edges < 8) begin
      @(negedge clk);
      edges++;
    end
    check("latency_edges", 64'(edges), 64'd3);
    for (int w = 0; w < 4; w++) begin
      if (w == v.poke_word) begin
        start4 = 1'b1; row_addr4 = 8'd9;
      end
      if (w == v.stall_word) begin
        dout_ready4 = 1'b0;
        for (int s = 0; s < v.stall_len; s++) begin
          check($sformatf("stall_dout_w%0d", w), 64'(dout4), 64'(v.words[w]));
          check($sformatf("stall_idx_w%0d", w), 64'(word_idx4), 64'(w));
          check($sformatf("stall_valid_w%0d", w), 64'(dout_valid4), 64'd1);
          @(negedge clk);
        end
        dout_ready4 = 1'b1;
      end
      check($sformatf("dout_w%0d", w), 64'(dout4), 64'(v.words[w]));
      check($sformatf("idx_w%0d", w), 64'(word_idx4), 64'(w));
      check($sformatf("valid_w%0d", w), 64'(dout_valid4), 64'd1);
      check($sformatf("done_early_w%0d", w), 64'(done4), 64'd0);
      @(negedge clk);
      start4 = 1'b0;
    end
    check("done_pulse", 64'(done4), 64'd1);
    check("valid_after_last", 64'(dout_valid4), 64'd0);
    check("idx_after_last", 64'(word_idx4), 64'd0);
    check("dout_after_last", 64'(dout4), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(done4), 64'd0);
    check("busy_after_row", 64'(busy4), 64'd0);
    check("rd_addr_held", 64'(rd_addr4), 64'(v.addr));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t vecs [4];
    vec_t fresh;
    logic [15:0] seen [$];
    int edges, done_cyc, b_cyc, done_cnt;

    for (int i = 0; i < 256; i++) mem4[i] = {4{16'(i)}};
    mem4[5] = 64'h4444_3333_2222_1111;
    mem4[7] = 64'h0000_ffff_8001_a5a5;
    for (int k = 0; k < 25; k++) row_in25[k*16 +: 16] = 16'(k + 1);

    vecs[0] = '{addr: 8'd5, stall_word: -1, stall_len: 0, poke_word: -1,
                words: {16'h4444, 16'h3333, 16'h2222, 16'h1111}};
    vecs[1] = '{addr: 8'd5, stall_word: 1, stall_len: 3, poke_word: -1,
                words: {16'h4444, 16'h3333, 16'h2222, 16'h1111}};
    vecs[2] = '{addr: 8'd5, stall_word: -1, stall_len: 0, poke_word: 2,
                words: {16'h4444, 16'h3333, 16'h2222, 16'h1111}};
    vecs[3] = '{addr: 8'd7, stall_word: 0, stall_len: 1, poke_word: 3,
                words: {16'h0000, 16'hffff, 16'h8001, 16'ha5a5}};

    rst_n = 1'b0;
    start4 = 1'b0; row_addr4 = '0; dout_ready4 = 1'b0;
    start25 = 1'b0; row_addr25 = '0; dout_ready25 = 1'b0;
    #1;
    check("rst_rd_addr", 64'(rd_addr4), 64'd0);
    check("rst_dout", 64'(dout4), 64'd0);
    check("rst_valid", 64'(dout_valid4), 64'd0);
    check("rst_idx", 64'(word_idx4), 64'd0);
    check("rst_busy", 64'(busy4), 64'd0);
    check("rst_done", 64'(done4), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_row(vecs[i]);

    // reset after the second handshake aborts the row
    start4 = 1'b1; row_addr4 = 8'd5; dout_ready4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    edges = 0;
    while (!dout_valid4 && edges < 8) begin
      @(negedge clk);
      edges++;
    end
    repeat (2) @(negedge clk);
    check("pre_reset_dout", 64'(dout4), 64'h3333);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rd_addr", 64'(rd_addr4), 64'd0);
    check("mid_rst_dout", 64'(dout4), 64'd0);
    check("mid_rst_valid", 64'(dout_valid4), 64'd0);
    check("mid_rst_idx", 64'(word_idx4), 64'd0);
    check("mid_rst_busy", 64'(busy4), 64'd0);
    check("mid_rst_done", 64'(done4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("no_done_after_abort", 64'(done4), 64'd0);
    fresh = vecs[3];
    fresh.stall_word = -1;
    fresh.poke_word = -1;
    run_row(fresh);

    // back-to-back rows with start held high
    start4 = 1'b1; row_addr4 = 8'd5; dout_ready4 = 1'b1;
    @(negedge clk);
    row_addr4 = 8'd7;
    done_cyc = -1; b_cyc = -1; done_cnt = 0;
    for (int c = 0; c < 40 && done_cnt < 2; c++) begin
      if (dout_valid4 && dout_ready4) begin
        if (seen.size() == 4 && b_cyc < 0) b_cyc = c;
        seen.push_back(dout4);
      end
      if (done4) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_cyc = c;
          check("b2b_idle_at_done", 64'(busy4), 64'd0);
        end else begin
          start4 = 1'b0;
        end
      end
      if (done_cnt == 1 && c == done_cyc + 1)
        check("b2b_rd_addr_b", 64'(rd_addr4), 64'd7);
      @(negedge clk);
    end
    start4 = 1'b0;
    check("b2b_done_count", 64'(done_cnt), 64'd2);
    check("b2b_word_count", 64'(seen.size()), 64'd8);
    check("b2b_latency", 64'(b_cyc - done_cyc), 64'd3);
    for (int i = 0; i < 4 && i < seen.size(); i++)
      check($sformatf("b2b_a_w%0d", i), 64'(seen[i]), 64'(vecs[0].words[i]));
    for (int i = 4; i < 8 && i < seen.size(); i++)
      check($sformatf("b2b_b_w%0d", i - 4), 64'(seen[i]), 64'(vecs[3].words[i - 4]));
    @(negedge clk);
    check("b2b_idle_after", 64'(busy4), 64'd0);

    // default parameters: word k carries k+1
    start25 = 1'b1; row_addr25 = 8'd3; dout_ready25 = 1'b1;
    @(negedge clk);
    start25 = 1'b0;
    check("d25_rd_addr", 64'(rd_addr25), 64'd3);
    edges = 1;
    while (!dout_valid25 && edges < 8) begin
      @(negedge clk);
      edges++;
    end
    check("d25_latency", 64'(edges), 64'd3);
    for (int w = 0; w < 25; w++) begin
      check($sformatf("d25_dout_w%0d", w), 64'(dout25), 64'(w + 1));
      check($sformatf("d25_idx_w%0d", w), 64'(word_idx25), 64'(w));
      @(negedge clk);
    end
    check("d25_done", 64'(done25), 64'd1);
    check("d25_valid_low", 64'(dout_valid25), 64'd0);
    @(negedge clk);
    check("d25_done_low", 64'(done25), 64'd0);
    check("d25_busy_low", 64'(busy25), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
